// File: rtl/bp_me_clint_arbiter.sv
// Round-robin arbiter that shares one CLINT slice's single-beat BedRock port
// between num_req_p requesters, with one transaction in flight at a time.
module bp_me_clint_arbiter
  #(parameter int bp_params_p = 0
  , parameter int num_req_p   = 2
  , localparam int lg_num_req_lp = $clog2(num_req_p)
  // Config 0 is the default config with its 66-bit BedRock header.
  , localparam int mem_header_width_lp = (bp_params_p == 0) ? 66 : 72
  , localparam int dword_width_gp = 64
  )
  (input  logic                                      clk_i
  , input  logic                                     reset_n_i

  , input  logic [num_req_p*mem_header_width_lp-1:0] req_cmd_header_i
  , input  logic [num_req_p*dword_width_gp-1:0]      req_cmd_data_i
  , input  logic [num_req_p-1:0]                     req_cmd_v_i
  , input  logic [num_req_p-1:0]                     req_cmd_last_i
  , output logic [num_req_p-1:0]                     req_cmd_ready_and_o

  , output logic [num_req_p*mem_header_width_lp-1:0] req_resp_header_o
  , output logic [num_req_p*dword_width_gp-1:0]      req_resp_data_o
  , output logic [num_req_p-1:0]                     req_resp_v_o
  , output logic [num_req_p-1:0]                     req_resp_last_o
  , input  logic [num_req_p-1:0]                     req_resp_ready_and_i

  , output logic [mem_header_width_lp-1:0]           clint_cmd_header_o
  , output logic [dword_width_gp-1:0]                clint_cmd_data_o
  , output logic                                     clint_cmd_v_o
  , output logic                                     clint_cmd_last_o
  , input  logic                                     clint_cmd_ready_and_i

  , input  logic [mem_header_width_lp-1:0]           clint_resp_header_i
  , input  logic [dword_width_gp-1:0]                clint_resp_data_i
  , input  logic                                     clint_resp_v_i
  , input  logic                                     clint_resp_last_i
  , output logic                                     clint_resp_ready_and_o

  , output logic [num_req_p-1:0]                     grant_o
  , output logic [1:0]                               state_o
  );

  // Every port pair is valid/ready: a beat moves in a cycle where valid and
  // ready are both high; a raised valid holds with stable payload until then.

  typedef enum logic [1:0] {e_idle = 2'd0, e_cmd = 2'd1, e_resp = 2'd2} state_e;

  state_e                   state_r, state_n;
  logic [lg_num_req_lp-1:0] grant_r, grant_n;
  logic [lg_num_req_lp-1:0] last_r, last_n;
  logic [lg_num_req_lp-1:0] pick, pick_hi, pick_lo;
  logic                     pick_hi_v;
  logic [num_req_p-1:0]     grant_oh;

  logic [mem_header_width_lp-1:0] sel_cmd_header;
  logic [dword_width_gp-1:0]      sel_cmd_data;
  logic                           sel_cmd_v, sel_cmd_last, sel_resp_ready;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      grant_r <= '0;
      last_r  <= lg_num_req_lp'(num_req_p - 1);
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
    end
  end

  // Round-robin: lowest valid index above last_r, else lowest valid overall.
  always_comb begin
    pick_hi_v = 1'b0;
    pick_hi   = '0;
    pick_lo   = '0;
    for (int j = num_req_p - 1; j >= 0; j--) begin
      if (req_cmd_v_i[j]) begin
        if (lg_num_req_lp'(j) > last_r) begin
          pick_hi_v = 1'b1;
          pick_hi   = lg_num_req_lp'(j);
        end else begin
          pick_lo = lg_num_req_lp'(j);
        end
      end
    end
    pick = pick_hi_v ? pick_hi : pick_lo;
  end

  always_comb begin
    grant_oh       = '0;
    sel_cmd_header = '0;
    sel_cmd_data   = '0;
    sel_cmd_v      = 1'b0;
    sel_cmd_last   = 1'b0;
    sel_resp_ready = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_r == lg_num_req_lp'(i)) begin
        grant_oh[i]    = 1'b1;
        sel_cmd_header = req_cmd_header_i[i*mem_header_width_lp +: mem_header_width_lp];
        sel_cmd_data   = req_cmd_data_i[i*dword_width_gp +: dword_width_gp];
        sel_cmd_v      = req_cmd_v_i[i];
        sel_cmd_last   = req_cmd_last_i[i];
        sel_resp_ready = req_resp_ready_and_i[i];
      end
    end
  end

  always_comb begin
    state_n                = state_r;
    grant_n                = grant_r;
    last_n                 = last_r;
    clint_cmd_header_o     = '0;
    clint_cmd_data_o       = '0;
    clint_cmd_v_o          = 1'b0;
    clint_cmd_last_o       = 1'b0;
    clint_resp_ready_and_o = 1'b0;
    req_cmd_ready_and_o    = '0;
    req_resp_header_o      = '0;
    req_resp_data_o        = '0;
    req_resp_v_o           = '0;
    req_resp_last_o        = '0;
    grant_o                = '0;

    unique case (state_r)
      e_idle: begin
        if (|req_cmd_v_i) begin
          grant_n = pick;
          state_n = e_cmd;
        end
      end
      e_cmd: begin
        grant_o             = grant_oh;
        clint_cmd_header_o  = sel_cmd_header;
        clint_cmd_data_o    = sel_cmd_data;
        clint_cmd_v_o       = sel_cmd_v;
        clint_cmd_last_o    = sel_cmd_last;
        req_cmd_ready_and_o = grant_oh & {num_req_p{clint_cmd_ready_and_i}};
        if (sel_cmd_v && clint_cmd_ready_and_i && sel_cmd_last) state_n = e_resp;
      end
      e_resp: begin
        grant_o                = grant_oh;
        clint_resp_ready_and_o = sel_resp_ready;
        for (int i = 0; i < num_req_p; i++) begin
          if (grant_oh[i]) begin
            req_resp_header_o[i*mem_header_width_lp +: mem_header_width_lp] = clint_resp_header_i;
            req_resp_data_o[i*dword_width_gp +: dword_width_gp]              = clint_resp_data_i;
            req_resp_v_o[i]    = clint_resp_v_i;
            req_resp_last_o[i] = clint_resp_last_i;
          end
        end
        if (clint_resp_v_i && sel_resp_ready && clint_resp_last_i) begin
          last_n  = grant_r;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  assign state_o = state_r;

endmodule
